// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_ctrl
//  Description : VGA raster scan generator. Free-running x/y counters, sync
//                and blanking generation, RGB332 sprite/background mux with
//                RGB888 expansion, all aligned to a LATENCY-cycle pixel
//                source. Also produces a frame-start pulse and frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LATENCY  = 2     // pixel source latency, legal 1..4
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic [7:0]  data,
    input  logic        visible_flag,
    input  logic [7:0]  bg_color,
    output logic [9:0]  current_pixel_x,
    output logic [9:0]  current_pixel_y,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] c_Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               w_x_wrap;
    logic               w_y_wrap;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_act_raw;
    logic [LATENCY-1:0] r_hs_sr;
    logic [LATENCY-1:0] r_vs_sr;
    logic [LATENCY-1:0] r_act_sr;
    logic [7:0]         w_col_d;
    logic [7:0]         r_col;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank_n;
    logic               r_fs;
    logic [15:0]        r_fc;

    assign w_x_wrap  = (r_x == c_X_LAST);
    assign w_y_wrap  = (r_y == c_Y_LAST);
    assign w_hs_raw  = !((r_x >= c_HS_START) && (r_x < c_HS_END));
    assign w_vs_raw  = !((r_y >= c_VS_START) && (r_y < c_VS_END));
    assign w_act_raw = (r_x < c_X_ACT) && (r_y < c_Y_ACT);

    // Scan counters: x every cycle, y on each x wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else begin
            r_x <= w_x_wrap ? 10'd0 : r_x + 10'd1;
            if (w_x_wrap)
                r_y <= w_y_wrap ? 10'd0 : r_y + 10'd1;
        end
    end

    // Delay raw timing by LATENCY cycles to meet the pixel source data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs_sr  <= '1;
            r_vs_sr  <= '1;
            r_act_sr <= '0;
        end else begin
            r_hs_sr[0]  <= w_hs_raw;
            r_vs_sr[0]  <= w_vs_raw;
            r_act_sr[0] <= w_act_raw;
            for (int i = 1; i < LATENCY; i++) begin
                r_hs_sr[i]  <= r_hs_sr[i-1];
                r_vs_sr[i]  <= r_vs_sr[i-1];
                r_act_sr[i] <= r_act_sr[i-1];
            end
        end
    end

    // Sprite pixel when opaque, otherwise background; black outside active
    assign w_col_d = r_act_sr[LATENCY-1] ? (visible_flag ? data : bg_color) : 8'h00;

    // Output register stage: colour and syncs leave the block together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col     <= 8'h00;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
        end else begin
            r_col     <= w_col_d;
            r_hs      <= r_hs_sr[LATENCY-1];
            r_vs      <= r_vs_sr[LATENCY-1];
            r_blank_n <= r_act_sr[LATENCY-1];
        end
    end

    // Frame pulse and count track the undelayed counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fs <= 1'b0;
            r_fc <= 16'd0;
        end else begin
            r_fs <= w_x_wrap && w_y_wrap;
            if (w_x_wrap && w_y_wrap)
                r_fc <= r_fc + 16'd1;
        end
    end

    assign current_pixel_x = r_x;
    assign current_pixel_y = r_y;
    assign vga_r           = {r_col[7:5], r_col[7:5], r_col[7:6]};
    assign vga_g           = {r_col[4:2], r_col[4:2], r_col[4:3]};
    assign vga_b           = {r_col[1:0], r_col[1:0], r_col[1:0], r_col[1:0]};
    assign vga_hs          = r_hs;
    assign vga_vs          = r_vs;
    assign vga_blank_n     = r_blank_n;
    assign frame_start     = r_fs;
    assign frame_cnt       = r_fc;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_scan_ctrl
//  Description : Directed self-checking bench for vga_scan_ctrl using a
//                reduced raster (24 x 14) with LATENCY=2 and LATENCY=3 copies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 14
    localparam int FR = HT * VT;             // 336

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data, data3, bg_color;
    logic        visible_flag;

    logic [9:0]  x2, y2, x3, y3;
    logic [7:0]  r2, g2, b2, r3, g3, b3;
    logic        hs2, vs2, bl2, fs2, hs3, vs3, bl3, fs3;
    logic [15:0] fc2, fc3;

    int checks = 0, failures = 0;
    int n = 0, mode = 0, pulses = 0, hs_low = 0, vs_low = 0;
    logic [7:0] lcol, lcol3;

    always #5 clk = ~clk;

    vga_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .data(data), .visible_flag(visible_flag), .bg_color(bg_color),
        .current_pixel_x(x2), .current_pixel_y(y2), .vga_r(r2), .vga_g(g2), .vga_b(b2),
        .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bl2), .frame_start(fs2), .frame_cnt(fc2));

    vga_scan_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .data(data3), .visible_flag(visible_flag), .bg_color(bg_color),
        .current_pixel_x(x3), .current_pixel_y(y3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
        .vga_hs(hs3), .vga_vs(vs3), .vga_blank_n(bl3), .frame_start(fs3), .frame_cnt(fc3));

    function automatic int wrap(int m, int t);
        return ((m % t) + t) % t;
    endfunction

    function automatic logic [23:0] exp332(logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare one instance against the raster model at model cycle n
    task automatic check_dut(string tag, int lat, logic [9:0] x, logic [9:0] y,
                             logic [7:0] r, logic [7:0] g, logic [7:0] b,
                             logic hs, logic vs, logic bl, logic fs,
                             logic [15:0] fc, logic [7:0] lc);
        int p;
        int px;
        int py;
        logic hs_e, vs_e, bl_e;
        logic [23:0] c_e, c_a;
        p = n - lat - 1;
        chk({tag, "_x"},  32'(x),  32'(wrap(n, HT)));
        chk({tag, "_y"},  32'(y),  32'((n / HT) % VT));
        chk({tag, "_fs"}, 32'(fs), 32'((n > 0) && (n % FR == 0)));
        chk({tag, "_fc"}, 32'(fc), 32'(n / FR));
        if (p >= 0) begin
            px   = wrap(p, HT);
            py   = (p / HT) % VT;
            hs_e = !(px >= HA + HF && px < HA + HF + HS);
            vs_e = !(py >= VA + VF && py < VA + VF + VS);
            bl_e = (px < HA) && (py < VA);
        end else begin
            px   = 0;
            hs_e = 1'b1;
            vs_e = 1'b1;
            bl_e = 1'b0;
        end
        c_e = exp332(bl_e ? lc : 8'h00);
        chk({tag, "_hs"}, 32'(hs), 32'(hs_e));
        chk({tag, "_vs"}, 32'(vs), 32'(vs_e));
        chk({tag, "_blank_n"}, 32'(bl), 32'(bl_e));
        chk({tag, "_r"}, 32'(r), 32'(c_e[23:16]));
        chk({tag, "_g"}, 32'(g), 32'(c_e[15:8]));
        chk({tag, "_b"}, 32'(b), 32'(c_e[7:0]));
        if (mode == 2 && bl_e) begin
            c_a = exp332(8'(px));
            chk({tag, "_align_r"}, 32'(r), 32'(c_a[23:16]));
            chk({tag, "_align_b"}, 32'(b), 32'(c_a[7:0]));
        end
    endtask

    task automatic drive();
        case (mode)
            0: begin visible_flag = 1'b1; data = 8'hE0; data3 = 8'hE0; bg_color = 8'h03; end
            1: begin visible_flag = 1'b0; data = 8'hE0; data3 = 8'hE0; bg_color = 8'b011_101_10; end
            default: begin
                visible_flag = 1'b1;
                data         = 8'(wrap(n - 2, HT));
                data3        = 8'(wrap(n - 3, HT));
                bg_color     = 8'h03;
            end
        endcase
    endtask

    task automatic tick();
        lcol  = visible_flag ? data  : bg_color;
        lcol3 = visible_flag ? data3 : bg_color;
        @(posedge clk);
        n++;
        @(negedge clk);
        check_dut("d2", 2, x2, y2, r2, g2, b2, hs2, vs2, bl2, fs2, fc2, lcol);
        check_dut("d3", 3, x3, y3, r3, g3, b3, hs3, vs3, bl3, fs3, fc3, lcol3);
        if (fs2 === 1'b1) pulses++;
        if (hs2 === 1'b0) hs_low++;
        if (vs2 === 1'b0) vs_low++;
        drive();
    endtask

    initial begin
        rst  = 1'b0;
        mode = 0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n = 0;
        lcol = 8'h00;
        check_dut("rst2", 2, x2, y2, r2, g2, b2, hs2, vs2, bl2, fs2, fc2, lcol);
        check_dut("rst3", 3, x3, y3, r3, g3, b3, hs3, vs3, bl3, fs3, fc3, lcol);
        rst = 1'b1;

        // Frame 1: opaque red sprite over blue background
        repeat (100) tick();
        chk("red_r", 32'(r2), 32'h00FF);
        chk("red_g", 32'(g2), 32'h0000);
        chk("red_b", 32'(b2), 32'h0000);
        repeat (FR - 100) tick();
        chk("frame1_pulses", 32'(pulses), 32'd1);
        chk("frame1_fc", 32'(fc2), 32'd1);
        chk("hs_low_cycles", 32'(hs_low), 32'(HS * VT));
        chk("vs_low_cycles", 32'(vs_low), 32'(VS * HT));

        // Frame 2: transparent sprite, background colour shows
        mode = 1;
        drive();
        repeat (100) tick();
        chk("bg_r", 32'(r2), 32'h006D);
        chk("bg_g", 32'(g2), 32'h00B6);
        chk("bg_b", 32'(b2), 32'h00AA);
        repeat (FR - 100) tick();

        // Frame 3: data tracks delayed x for alignment
        mode = 2;
        drive();
        repeat (FR) tick();

        // Mid-frame asynchronous reset at x=5, y=3
        mode = 0;
        drive();
        repeat (3 * HT + 5) tick();
        chk("pre_rst_x", 32'(x2), 32'd5);
        chk("pre_rst_y", 32'(y2), 32'd3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n = 0;
        lcol = 8'h00;
        lcol3 = 8'h00;
        check_dut("arst2", 2, x2, y2, r2, g2, b2, hs2, vs2, bl2, fs2, fc2, lcol);
        check_dut("arst3", 3, x3, y3, r3, g3, b3, hs3, vs3, bl3, fs3, fc3, lcol3);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        n      = 0;
        pulses = 0;
        repeat (FR - 1) tick();
        chk("post_rst_no_pulse", 32'(pulses), 32'd0);
        tick();
        chk("post_rst_pulse", 32'(pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels; H_TOTAL = sum of H_ACTIVE, H_FP, H_SYNC, H_BP (default 800).
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porches and sync in lines; V_TOTAL = sum of V_ACTIVE, V_FP, V_SYNC, V_BP (default 525).
REQ-005 Parameter LATENCY, default 2: clk cycles from current_pixel_x/y change to valid data/visible_flag from the sprite ROM block; legal range 1..4.
REQ-006 Port clk, input, 1: pixel clock, 25 MHz nominal; all logic on rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-low reset.
REQ-008 Port data, input, 8: sprite pixel, RGB332 (R=[7:5], G=[4:2], B=[1:0]).
REQ-009 Port visible_flag, input, 1: sprite pixel opaque.
REQ-010 Port bg_color, input, 8: RGB332 background, sampled in the same cycle as data.
REQ-011 Port current_pixel_x, output, 10: horizontal scan counter, 0..H_TOTAL-1.
REQ-012 Port current_pixel_y, output, 10: vertical scan counter, 0..V_TOTAL-1.
REQ-013 Ports vga_r, vga_g, vga_b, output, 8 each: expanded colour.
REQ-014 Ports vga_hs, vga_vs, output, 1 each: sync pulses, active-low.
REQ-015 Port vga_blank_n, output, 1: high during the active region.
REQ-016 Port frame_start, output, 1: one-cycle pulse at the start of each frame.
REQ-017 Port frame_cnt, output, 16: count of completed frames.

Function
REQ-018 current_pixel_x shall increment every cycle; H_TOTAL-1 wraps to 0.
REQ-019 current_pixel_y shall increment only when current_pixel_x wraps; V_TOTAL-1 wraps to 0 in that cycle.
REQ-020 Raw hsync is low for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; raw vsync is low for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; raw active is x < H_ACTIVE and y < V_ACTIVE.
REQ-021 Raw hsync, vsync and active shall pass through a LATENCY-deep shift register, then one output register, so that vga_hs, vga_vs and vga_blank_n align with the colour outputs.
REQ-022 Colour register input is zero when delayed active is low; otherwise it is data if visible_flag is high, else bg_color.
REQ-023 RGB332 expansion by bit replication: r = {c[7:5],c[7:5],c[7:6]}; g = {c[4:2],c[4:2],c[4:3]}; b = {c[1:0],c[1:0],c[1:0],c[1:0]}.
REQ-024 Total latency: counters at (x,y) in cycle t give vga_* for that pixel at t+LATENCY+1.
REQ-025 frame_start is registered and high for exactly the one cycle after x and y both wrap to 0 (x=0, y=0 visible on counters).
REQ-026 frame_cnt increments by 1 in the same cycle frame_start asserts; wraps 65535 to 0.
REQ-027 frame_start and frame_cnt use undelayed counters; they are not aligned to the LATENCY pipeline.
REQ-028 data, visible_flag and bg_color are used only when delayed active is high; the block has no other dependence on them.

Reset
REQ-029 While rst is low: counters 0, vga_r/g/b 0, vga_hs 1, vga_vs 1, vga_blank_n 0, frame_start 0, frame_cnt 0, all delay stages set to their inactive values (hs 1, vs 1, active 0).
REQ-030 Reset asserted mid-frame takes effect immediately, without waiting for a clock edge; after release, scanning starts at x=0, y=0; no frame_start pulse for the reset-start frame; first pulse at the first wrap.

Verification
REQ-031 Release reset, run 800*525 cycles -> x wraps at 799, y wraps at 524; exactly one frame_start pulse, frame_cnt=1.
REQ-032 Measure syncs -> vga_hs low 96 cycles per 800, falling at x=656+LATENCY+1 cycles delay; vga_vs low exactly 2 lines, starting line 490.
REQ-033 Hold visible_flag=1, data=8'hE0, bg=8'h03 -> vga_r=8'hFF, g=0, b=0 in active region; blanking gives all zero and vga_blank_n=0.
REQ-034 visible_flag=0, bg=8'b011_101_10 -> vga_r=8'h6D, vga_g=8'hB6, vga_b=8'hAA.
REQ-035 Drive data = low byte of the x value delayed LATENCY cycles, visible_flag=1 -> vga colour for output pixel n matches x=n (alignment check, LATENCY=2 and 3).
REQ-036 Pull rst low at x=300, y=200 -> all outputs at reset values before the next edge; after release, first frame_start after 420000 cycles.
